// File: rtl/syn_sram_acc_arb.sv
// Two-agent SRAM access arbiter: agent 0 (read-only, high priority) and agent 1 (read/write).
// Grants one access per cycle onto a registered bus and inserts an idle cycle on write-to-read.
// Bounds agent-1 starvation and returns read data through a 3-stage tag pipe.
module syn_sram_acc_arb #(
  parameter int unsigned ADDR_W       = 18,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic              clk_ir,
  input  logic              rst_sync_l,
  input  logic              a0_req,
  input  logic [ADDR_W-1:0] a0_addr,
  output logic              a0_ready,
  output logic              a0_rd_valid,
  input  logic              a1_req,
  input  logic              a1_wr,
  input  logic [ADDR_W-1:0] a1_addr,
  input  logic [15:0]       a1_wr_data,
  input  logic [1:0]        a1_be,
  output logic              a1_ready,
  output logic              a1_rd_valid,
  output logic [15:0]       rd_data,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_wr_data,
  output logic [1:0]        sram_be,
  output logic              sram_cs,
  output logic              sram_rd_en,
  output logic              sram_wr_en,
  input  logic [15:0]       sram_rd_data
);

  localparam logic [7:0] LimitCnt = 8'(STARVE_LIMIT);

  logic [7:0]        r_starve_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_wr_data;
  logic [1:0]        r_be;
  logic              r_cs;
  logic              r_rd_en;
  logic              r_wr_en;
  // Tag pipe, index 0 = youngest; id 1 = agent 1.
  logic [2:0]        r_tag_v;
  logic [2:0]        r_tag_id;

  logic              w_force_a1;
  logic              w_win_a0;
  logic              w_win_a1;
  logic              w_win_rd;
  logic              w_turn;
  logic              w_acc0;
  logic              w_acc1;
  logic              w_ld_v;
  logic [7:0]        w_starve_d;

  // Arbitration: forced agent 1, then agent 0, then agent 1; stall a read right after a write.
  always_comb begin
    w_force_a1 = a1_req && (r_starve_cnt == LimitCnt);
    w_win_a1   = w_force_a1 || (a1_req && !a0_req);
    w_win_a0   = a0_req && !w_force_a1;
    w_win_rd   = w_win_a0 || (w_win_a1 && !a1_wr);
    w_turn     = r_wr_en && w_win_rd;
    w_acc0     = w_win_a0 && !w_turn;
    w_acc1     = w_win_a1 && !w_turn;
    w_ld_v     = w_acc0 || (w_acc1 && !a1_wr);
  end

  // Starvation counter next state: hold on turnaround, clear on agent-1 win or idle agent 1.
  always_comb begin
    w_starve_d = r_starve_cnt;
    if (w_turn) begin
      w_starve_d = r_starve_cnt;
    end else if (!a1_req || w_acc1) begin
      w_starve_d = 8'd0;
    end else if (w_acc0 && (r_starve_cnt != LimitCnt)) begin
      w_starve_d = r_starve_cnt + 8'd1;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) begin
      r_starve_cnt <= 8'd0;
    end else begin
      r_starve_cnt <= w_starve_d;
    end
  end

  // Bus register: load on accept, otherwise drop strobes and hold the data fields.
  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) begin
      r_addr    <= '0;
      r_wr_data <= 16'd0;
      r_be      <= 2'b00;
      r_cs      <= 1'b0;
      r_rd_en   <= 1'b0;
      r_wr_en   <= 1'b0;
    end else if (w_acc0) begin
      r_addr    <= a0_addr;
      r_be      <= 2'b11;
      r_cs      <= 1'b1;
      r_rd_en   <= 1'b1;
      r_wr_en   <= 1'b0;
    end else if (w_acc1) begin
      r_addr    <= a1_addr;
      r_wr_data <= a1_wr_data;
      r_be      <= a1_wr ? a1_be : 2'b11;
      r_cs      <= 1'b1;
      r_rd_en   <= !a1_wr;
      r_wr_en   <= a1_wr;
    end else begin
      r_cs      <= 1'b0;
      r_rd_en   <= 1'b0;
      r_wr_en   <= 1'b0;
    end
  end

  // Read tag pipe, aligned so stage 3 meets the driver's registered read data.
  always_ff @(posedge clk_ir or negedge rst_sync_l) begin
    if (!rst_sync_l) begin
      r_tag_v  <= 3'b000;
      r_tag_id <= 3'b000;
    end else begin
      r_tag_v  <= {r_tag_v[1:0], w_ld_v};
      r_tag_id <= {r_tag_id[1:0], w_acc1};
    end
  end

  // Output mapping.
  always_comb begin
    a0_ready     = w_acc0;
    a1_ready     = w_acc1;
    a0_rd_valid  = r_tag_v[2] && !r_tag_id[2];
    a1_rd_valid  = r_tag_v[2] && r_tag_id[2];
    rd_data      = r_tag_v[2] ? sram_rd_data : 16'd0;
    sram_addr    = r_addr;
    sram_wr_data = r_wr_data;
    sram_be      = r_be;
    sram_cs      = r_cs;
    sram_rd_en   = r_rd_en;
    sram_wr_en   = r_wr_en;
  end

endmodule

// File: tb/tb_syn_sram_acc_arb.sv
// Bench for syn_sram_acc_arb: SRAM driver model, transaction-level reference model,
// table vectors, directed corner sequences and randomized traffic.
module tb_syn_sram_acc_arb;

  localparam int AW    = 18;
  localparam int LIMIT = 16;

  logic          clk_ir = 1'b0;
  logic          rst_sync_l = 1'b0;
  logic          a0_req = 1'b0;
  logic [AW-1:0] a0_addr = '0;
  logic          a0_ready;
  logic          a0_rd_valid;
  logic          a1_req = 1'b0;
  logic          a1_wr = 1'b0;
  logic [AW-1:0] a1_addr = '0;
  logic [15:0]   a1_wr_data = 16'd0;
  logic [1:0]    a1_be = 2'b11;
  logic          a1_ready;
  logic          a1_rd_valid;
  logic [15:0]   rd_data;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_wr_data;
  logic [1:0]    sram_be;
  logic          sram_cs;
  logic          sram_rd_en;
  logic          sram_wr_en;
  logic [15:0]   sram_rd_data = 16'd0;

  syn_sram_acc_arb #(
    .ADDR_W      (AW),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk_ir      (clk_ir),
    .rst_sync_l  (rst_sync_l),
    .a0_req      (a0_req),
    .a0_addr     (a0_addr),
    .a0_ready    (a0_ready),
    .a0_rd_valid (a0_rd_valid),
    .a1_req      (a1_req),
    .a1_wr       (a1_wr),
    .a1_addr     (a1_addr),
    .a1_wr_data  (a1_wr_data),
    .a1_be       (a1_be),
    .a1_ready    (a1_ready),
    .a1_rd_valid (a1_rd_valid),
    .rd_data     (rd_data),
    .sram_addr   (sram_addr),
    .sram_wr_data(sram_wr_data),
    .sram_be     (sram_be),
    .sram_cs     (sram_cs),
    .sram_rd_en  (sram_rd_en),
    .sram_wr_en  (sram_wr_en),
    .sram_rd_data(sram_rd_data)
  );

  always #5 clk_ir = ~clk_ir;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Memory contents (driver-side array and the model's golden copy).
  logic [15:0] mem     [0:1023];
  logic [15:0] ref_mem [0:1023];

  // Driver model: registers pins one cycle after the bus, registers DQ at the end of that cycle.
  logic          d_rd = 1'b0;
  logic          d_wr = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [1:0]    d_be = 2'b00;
  logic [15:0]   d_data = 16'd0;
  initial begin
    forever begin
      @(posedge clk_ir);
      if (d_rd) sram_rd_data <= mem[d_addr[9:0]];
      if (d_wr && d_be[0]) mem[d_addr[9:0]][7:0] = d_data[7:0];
      if (d_wr && d_be[1]) mem[d_addr[9:0]][15:8] = d_data[15:8];
      d_rd   <= sram_rd_en;
      d_wr   <= sram_wr_en;
      d_addr <= sram_addr;
      d_be   <= sram_be;
      d_data <= sram_wr_data;
    end
  end

  // Reference model, transaction level.
  typedef struct packed {
    logic          cs;
    logic          rd;
    logic          wr;
    logic [1:0]    be;
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } bus_t;

  typedef struct {
    int          due;
    bit          id;
    logic [15:0] data;
  } ret_t;

  bus_t          m_bus;
  int            m_streak;
  int            cyc;
  ret_t          rq[$];
  bit            p_acc, p_id, p_stall, p_a1req, p_wr;
  logic [AW-1:0] p_addr;
  logic [15:0]   p_data;
  logic [1:0]    p_be;
  int            win;
  bit            w_rd, w_stall, e_r0, e_r1;
  logic [17:0]   e_ret;

  initial begin
    m_bus = '0; m_streak = 0; cyc = 0; p_acc = 0;
    forever begin
      @(negedge clk_ir);
      p_acc = 0;
      if (!rst_sync_l) begin
        m_bus = '0;
        m_streak = 0;
        rq.delete();
      end else begin
        if (a1_req && m_streak >= LIMIT) win = 1;
        else if (a0_req)                 win = 0;
        else if (a1_req)                 win = 1;
        else                             win = -1;
        w_rd    = (win == 0) || (win == 1 && !a1_wr);
        w_stall = m_bus.wr && (win >= 0) && w_rd;
        e_r0    = (win == 0) && !w_stall;
        e_r1    = (win == 1) && !w_stall;
        chk("ready", 64'({a0_ready, a1_ready}), 64'({e_r0, e_r1}));
        chk("bus", 64'({sram_cs, sram_rd_en, sram_wr_en, sram_be, sram_addr, sram_wr_data}),
            64'(m_bus));
        e_ret = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
          e_ret = {(rq[0].id ? 2'b01 : 2'b10), rq[0].data};
          void'(rq.pop_front());
        end
        chk("rd_return", 64'({a0_rd_valid, a1_rd_valid, rd_data}), 64'(e_ret));
        p_acc   = e_r0 || e_r1;
        p_id    = e_r1;
        p_stall = w_stall;
        p_a1req = a1_req;
        p_addr  = e_r0 ? a0_addr : a1_addr;
        p_wr    = e_r1 && a1_wr;
        p_data  = a1_wr_data;
        p_be    = a1_be;
      end
      @(posedge clk_ir);
      if (rst_sync_l) begin
        if (p_acc) begin
          m_bus.cs   = 1'b1;
          m_bus.rd   = !p_wr;
          m_bus.wr   = p_wr;
          m_bus.addr = p_addr;
          m_bus.be   = p_wr ? p_be : 2'b11;
          if (p_id) m_bus.data = p_data;
          if (p_wr && p_be[0]) ref_mem[p_addr[9:0]][7:0] = p_data[7:0];
          if (p_wr && p_be[1]) ref_mem[p_addr[9:0]][15:8] = p_data[15:8];
          if (!p_wr) rq.push_back('{cyc + 3, p_id, ref_mem[p_addr[9:0]]});
          if (!p_id && p_a1req) m_streak = (m_streak + 1 > LIMIT) ? LIMIT : m_streak + 1;
          else m_streak = 0;
        end else begin
          m_bus.cs = 1'b0;
          m_bus.rd = 1'b0;
          m_bus.wr = 1'b0;
          if (!p_stall) m_streak = 0;
        end
        cyc++;
      end
    end
  end

  // Table vectors: combinational grant decisions from a known idle state.
  typedef struct packed {
    bit pre_wr;
    bit a0;
    bit a1;
    bit wr;
    bit r0;
    bit r1;
    bit cs;
    bit bwr;
  } tv_t;
  tv_t tv [11];

  task automatic nxt();
    @(posedge clk_ir);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_ir);
  endtask

  task automatic idle(input int n);
    a0_req = 1'b0;
    a1_req = 1'b0;
    for (int i = 0; i < n; i++) nxt();
  endtask

  bit acc0, acc1;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 16'(i * 40503 + 7);
      ref_mem[i] = 16'(i * 40503 + 7);
    end
    mem[10'h123]     = 16'hBEEF;
    ref_mem[10'h123] = 16'hBEEF;

    //           pre a0 a1 wr r0 r1 cs bwr
    tv[0]  = 8'b0_0_0_0_0_0_0_0;
    tv[1]  = 8'b0_1_0_0_1_0_1_0;
    tv[2]  = 8'b0_0_1_0_0_1_1_0;
    tv[3]  = 8'b0_0_1_1_0_1_1_1;
    tv[4]  = 8'b0_1_1_0_1_0_1_0;
    tv[5]  = 8'b0_1_1_1_1_0_1_0;
    tv[6]  = 8'b1_1_0_0_0_0_0_0;
    tv[7]  = 8'b1_0_1_1_0_1_1_1;
    tv[8]  = 8'b1_0_1_0_0_0_0_0;
    tv[9]  = 8'b1_1_1_1_0_0_0_0;
    tv[10] = 8'b1_0_0_0_0_0_0_0;

    // Reset and idle.
    repeat (2) begin
      smp();
      chk("reset_outs", 64'({sram_cs, sram_rd_en, sram_wr_en, sram_be, sram_addr, sram_wr_data,
                            a0_ready, a1_ready, a0_rd_valid, a1_rd_valid, rd_data}), 64'd0);
    end
    nxt();
    rst_sync_l = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("idle_bus", 64'({sram_cs, sram_rd_en, sram_wr_en, sram_addr}), 64'd0);
      chk("idle_rdv", 64'({a0_rd_valid, a1_rd_valid}), 64'd0);
      nxt();
    end

    // Table vectors.
    for (int i = 0; i < 11; i++) begin
      if (tv[i].pre_wr) begin
        a0_req = 1'b0; a1_req = 1'b1; a1_wr = 1'b1; a1_addr = 18'h00040;
        a1_wr_data = 16'(16'h1200 + i); a1_be = 2'b11;
        nxt();
      end
      a0_req = tv[i].a0; a0_addr = 18'h00041;
      a1_req = tv[i].a1; a1_wr = tv[i].wr; a1_addr = 18'h00042;
      a1_wr_data = 16'(16'hC300 + i); a1_be = 2'b01;
      smp();
      chk("tv_ready", 64'({a0_ready, a1_ready}), 64'({tv[i].r0, tv[i].r1}));
      nxt();
      a0_req = 1'b0; a1_req = 1'b0;
      smp();
      chk("tv_bus", 64'({sram_cs, sram_wr_en}), 64'({tv[i].cs, tv[i].bwr}));
      nxt();
      nxt();
    end
    idle(4);

    // Single agent-0 read.
    a0_req = 1'b1; a0_addr = 18'h00123;
    smp();
    chk("s0_ready", 64'(a0_ready), 64'd1);
    nxt();
    a0_req = 1'b0;
    smp();
    chk("s0_bus", 64'({sram_cs, sram_rd_en, sram_addr}), 64'({2'b11, 18'h00123}));
    chk("s0_rdv_c1", 64'(a0_rd_valid), 64'd0);
    nxt();
    smp();
    chk("s0_rdv_c2", 64'(a0_rd_valid), 64'd0);
    nxt();
    smp();
    chk("s0_ret", 64'({a0_rd_valid, rd_data}), 64'({1'b1, 16'hBEEF}));
    nxt();
    smp();
    chk("s0_rdv_c4", 64'(a0_rd_valid), 64'd0);
    idle(3);

    // Write then read with turnaround.
    a1_req = 1'b1; a1_wr = 1'b1; a1_addr = 18'h00010; a1_wr_data = 16'h5A5A; a1_be = 2'b11;
    smp();
    chk("wr_ready", 64'(a1_ready), 64'd1);
    nxt();
    a1_wr = 1'b0;
    smp();
    chk("wr_bus", 64'({sram_wr_en, sram_be, sram_wr_data}), 64'({1'b1, 2'b11, 16'h5A5A}));
    chk("turn_stall", 64'({a0_ready, a1_ready}), 64'd0);
    nxt();
    smp();
    chk("turn_idle", 64'({sram_cs, sram_rd_en, sram_wr_en}), 64'd0);
    chk("rd_ready", 64'(a1_ready), 64'd1);
    nxt();
    a1_req = 1'b0;
    smp();
    chk("rd_bus", 64'({sram_rd_en, sram_addr}), 64'({1'b1, 18'h00010}));
    nxt();
    smp();
    nxt();
    smp();
    chk("wr_rd_ret", 64'({a1_rd_valid, rd_data}), 64'({1'b1, 16'h5A5A}));
    idle(3);

    // Starvation bound.
    for (int g = 0; g < 37; g++) begin
      a0_req = (g < 34); a0_addr = 18'h00200;
      a1_req = (g < 34); a1_wr = 1'b0; a1_addr = 18'h00300; a1_be = 2'(g);
      smp();
      if (g < 34)
        chk("starve_grant", 64'({a0_ready, a1_ready}),
            64'({(g % 17) != 16, (g % 17) == 16}));
      if (g >= 3) chk("starve_a1_rdv", 64'(a1_rd_valid), 64'(((g - 3) % 17) == 16));
      nxt();
    end
    idle(3);

    // Interleaved streaming reads.
    for (int k = 0; k < 11; k++) begin
      a0_req = (k < 8) && (k % 2 == 0); a0_addr = 18'(k);
      a1_req = (k < 8) && (k % 2 == 1); a1_wr = 1'b0; a1_addr = 18'(k);
      smp();
      if (k < 8) chk("il_ready", 64'({a0_ready, a1_ready}), 64'({k % 2 == 0, k % 2 == 1}));
      if (k >= 1 && k <= 8) chk("il_no_turn", 64'(sram_cs), 64'd1);
      if (k >= 3)
        chk("il_ret", 64'({a0_rd_valid, a1_rd_valid, rd_data}),
            64'({(k - 3) % 2 == 0, (k - 3) % 2 == 1, ref_mem[k - 3]}));
      chk("il_excl", 64'(a0_rd_valid && a1_rd_valid), 64'd0);
      nxt();
    end
    idle(3);

    // Reset mid-flight.
    a0_req = 1'b1; a0_addr = 18'h00055;
    smp();
    chk("rf_ready", 64'(a0_ready), 64'd1);
    nxt();
    a0_req = 1'b0;
    smp();
    #2 rst_sync_l = 1'b0;
    nxt();
    smp();
    chk("rf_in_reset", 64'({sram_cs, sram_rd_en, sram_addr, a0_rd_valid, a1_rd_valid}), 64'd0);
    nxt();
    rst_sync_l = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp();
      chk("rf_no_rdv", 64'({a0_rd_valid, a1_rd_valid}), 64'd0);
      nxt();
    end
    a0_req = 1'b1; a0_addr = 18'h00056;
    smp();
    chk("rf2_ready", 64'(a0_ready), 64'd1);
    nxt();
    a0_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      smp();
      chk("rf2_early", 64'(a0_rd_valid), 64'd0);
      nxt();
    end
    smp();
    chk("rf2_ret", 64'({a0_rd_valid, rd_data}), 64'({1'b1, ref_mem[10'h056]}));
    idle(3);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 800; n++) begin
      smp();
      acc0 = a0_req && a0_ready;
      acc1 = a1_req && a1_ready;
      nxt();
      if (!a0_req || acc0) begin
        a0_req  = ($urandom_range(0, 99) < 55);
        a0_addr = 18'($urandom_range(0, 63));
      end
      if (!a1_req || acc1) begin
        a1_req     = ($urandom_range(0, 99) < 65);
        a1_wr      = 1'($urandom_range(0, 1));
        a1_addr    = 18'($urandom_range(0, 63));
        a1_wr_data = 16'($urandom);
        a1_be      = 2'($urandom_range(0, 3));
      end
    end
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
